mem_arbiter: RTL and testbench

- Owns the single byte-wide RAM port and shares it between two requesters: instruction fetch and the load/store unit.
- Accepts one request at a time and sequences it as 1, 2 or 4 byte-serial RAM accesses.
- Assembles little-endian read data and returns a one-cycle completion pulse to the requester.
- Honours branch-mispredict flush for in-flight instruction reads.

---
 rtl/mem_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one byte-wide synchronous RAM port between instruction fetch and the
// load/store unit. One request is accepted at a time and turned into 1, 2 or
// 4 byte-serial RAM accesses. Read bytes are assembled little-endian, and a
// one-cycle completion pulse goes back to the requester.
//
// Optional build macro: MEM_ARB_FAIR_EN
//   defined   : round-robin between the two sources when both are pending
//   undefined : fixed priority, the data request always wins
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   rdy        in   global ready; 0 freezes every register
//   mistaken   in   mispredict flush, aborts an instruction read
//   instEn     in   fetch request, held until instOutEn
//   instAddr   in   fetch address (4 bytes)
//   instOutEn  out  one-cycle pulse, inst valid
//   inst       out  fetched instruction
//   dataEn     in   LSU request, held until dataOutEn
//   dataWr     in   1 = store, 0 = load
//   dataLen    in   00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes
//   dataAddr   in   LSU address, any alignment
//   dataIn     in   store data, byte 0 in bits [7:0]
//   dataOutEn  out  one-cycle pulse, load data valid / store done
//   dataOut    out  load data, zero-extended
//   ramAddr    out  RAM byte address
//   ramWr      out  RAM write strobe
//   ramDout    out  RAM write byte
//   ramDin     in   RAM read byte, two edges after ramAddr is registered
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              mistaken,
  input  logic              instEn,
  input  logic [ADDR_W-1:0] instAddr,
  output logic              instOutEn,
  output logic [31:0]       inst,
  input  logic              dataEn,
  input  logic              dataWr,
  input  logic [1:0]        dataLen,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [31:0]       dataIn,
  output logic              dataOutEn,
  output logic [31:0]       dataOut,
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramWr,
  output logic [7:0]        ramDout,
  input  logic [7:0]        ramDin
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;       // edges completed since the grant edge
  logic [2:0]        len_reg, len_next;       // byte count N
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              src_data_reg, src_data_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       rbuf_reg, rbuf_next;
  logic              inst_out_en_reg, inst_out_en_next;
  logic [31:0]       inst_reg, inst_next;
  logic              data_out_en_reg, data_out_en_next;
  logic [31:0]       data_out_reg, data_out_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic              ram_wr_reg, ram_wr_next;
  logic [7:0]        ram_dout_reg, ram_dout_next;
`ifdef MEM_ARB_FAIR_EN
  logic              last_data_reg, last_data_next;  // 0 = last grant was inst
`endif

  logic [2:0]  edge_k;     // index of the edge being computed, relative to grant
  logic [1:0]  cap_idx;
  logic        cap_en;
  logic [31:0] cap_word;
  logic [7:0]  wr_byte;
  logic [2:0]  req_len;
  logic        inst_req;
  logic        grant_data;
  logic        grant_inst;

  assign edge_k = cnt_reg + 3'd1;

  // ramDin carries byte i at edge i+2, so the byte landing now is cnt_reg-1.
  assign cap_en  = (state_reg == READ) && (cnt_reg != 3'd0);
  assign cap_idx = cnt_reg[1:0] - 2'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cap
      assign cap_word[8*gi +: 8] = (cap_en && (cap_idx == 2'(gi))) ? ramDin
                                                                  : rbuf_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    wr_byte = wdata_reg[7:0];
    case (edge_k[1:0])
      2'd1:    wr_byte = wdata_reg[15:8];
      2'd2:    wr_byte = wdata_reg[23:16];
      2'd3:    wr_byte = wdata_reg[31:24];
      default: wr_byte = wdata_reg[7:0];
    endcase
  end

  // Length code 10 is treated like 11 (full word).
  assign req_len  = (dataLen == 2'b00) ? 3'd1 :
                    (dataLen == 2'b01) ? 3'd2 : 3'd4;

  // A fetch raised together with a flush is stale and never granted.
  assign inst_req = instEn && !mistaken;

`ifdef MEM_ARB_FAIR_EN
  assign grant_data = dataEn && (!inst_req || !last_data_reg);
`else
  assign grant_data = dataEn;
`endif
  assign grant_inst = inst_req && !grant_data;

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    len_next         = len_reg;
    addr_next        = addr_reg;
    src_data_next    = src_data_reg;
    wdata_next       = wdata_reg;
    rbuf_next        = rbuf_reg;
    inst_out_en_next = 1'b0;
    inst_next        = inst_reg;
    data_out_en_next = 1'b0;
    data_out_next    = data_out_reg;
    ram_addr_next    = ram_addr_reg;
    ram_wr_next      = 1'b0;
    ram_dout_next    = ram_dout_reg;
`ifdef MEM_ARB_FAIR_EN
    last_data_next   = last_data_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (grant_data || grant_inst) begin
          src_data_next = grant_data;
          addr_next     = grant_data ? dataAddr : instAddr;
          len_next      = grant_data ? req_len : 3'd4;
          wdata_next    = dataIn;
          rbuf_next     = 32'h0;
          cnt_next      = 3'd0;
          ram_addr_next = grant_data ? dataAddr : instAddr;
`ifdef MEM_ARB_FAIR_EN
          last_data_next = grant_data;
`endif
          if (grant_data && dataWr) begin
            state_next    = WRITE;
            ram_wr_next   = 1'b1;
            ram_dout_next = dataIn[7:0];
          end else begin
            state_next    = READ;
          end
        end
      end

      READ: begin
        cnt_next  = edge_k;
        rbuf_next = cap_word;
        if (!src_data_reg && mistaken) begin
          // Flushed fetch: drop it; bytes still in the RAM pipe are never captured.
          state_next = IDLE;
        end else begin
          if (edge_k < len_reg) begin
            ram_addr_next = addr_reg + ADDR_W'(edge_k);
          end
          if (edge_k == len_reg + 3'd1) begin
            state_next = IDLE;
            if (src_data_reg) begin
              data_out_en_next = 1'b1;
              data_out_next    = cap_word;
            end else begin
              inst_out_en_next = 1'b1;
              inst_next        = cap_word;
            end
          end
        end
      end

      WRITE: begin
        cnt_next = edge_k;
        if (edge_k < len_reg) begin
          ram_addr_next = addr_reg + ADDR_W'(edge_k);
          ram_wr_next   = 1'b1;
          ram_dout_next = wr_byte;
        end else begin
          state_next       = IDLE;
          data_out_en_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= 3'd0;
      len_reg         <= 3'd0;
      addr_reg        <= '0;
      src_data_reg    <= 1'b0;
      wdata_reg       <= 32'h0;
      rbuf_reg        <= 32'h0;
      inst_out_en_reg <= 1'b0;
      inst_reg        <= 32'h0;
      data_out_en_reg <= 1'b0;
      data_out_reg    <= 32'h0;
      ram_addr_reg    <= '0;
      ram_wr_reg      <= 1'b0;
      ram_dout_reg    <= 8'h0;
`ifdef MEM_ARB_FAIR_EN
      last_data_reg   <= 1'b0;
`endif
    end else if (rdy) begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      len_reg         <= len_next;
      addr_reg        <= addr_next;
      src_data_reg    <= src_data_next;
      wdata_reg       <= wdata_next;
      rbuf_reg        <= rbuf_next;
      inst_out_en_reg <= inst_out_en_next;
      inst_reg        <= inst_next;
      data_out_en_reg <= data_out_en_next;
      data_out_reg    <= data_out_next;
      ram_addr_reg    <= ram_addr_next;
      ram_wr_reg      <= ram_wr_next;
      ram_dout_reg    <= ram_dout_next;
`ifdef MEM_ARB_FAIR_EN
      last_data_reg   <= last_data_next;
`endif
    end
  end

  assign instOutEn = inst_out_en_reg;
  assign inst      = inst_reg;
  assign dataOutEn = data_out_en_reg;
  assign dataOut   = data_out_reg;
  assign ramAddr   = ram_addr_reg;
  assign ramWr     = ram_wr_reg;
  assign ramDout   = ram_dout_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a synchronous byte RAM model. A
// transaction-level reference schedules, for each grant, what the RAM port and
// completion pulses must show on every following edge; a negedge process
// compares the DUT against it. Directed literal checks pin latencies and data.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 32;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        rdy       = 1'b1;
  logic        mistaken  = 1'b0;
  logic        instEn    = 1'b0;
  logic [31:0] instAddr  = 32'h0;
  logic        instOutEn;
  logic [31:0] inst;
  logic        dataEn    = 1'b0;
  logic        dataWr    = 1'b0;
  logic [1:0]  dataLen   = 2'b00;
  logic [31:0] dataAddr  = 32'h0;
  logic [31:0] dataIn    = 32'h0;
  logic        dataOutEn;
  logic [31:0] dataOut;
  logic [31:0] ramAddr;
  logic        ramWr;
  logic [7:0]  ramDout;
  logic [7:0]  ramDin    = 8'h00;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .mistaken  (mistaken),
    .instEn    (instEn),
    .instAddr  (instAddr),
    .instOutEn (instOutEn),
    .inst      (inst),
    .dataEn    (dataEn),
    .dataWr    (dataWr),
    .dataLen   (dataLen),
    .dataAddr  (dataAddr),
    .dataIn    (dataIn),
    .dataOutEn (dataOutEn),
    .dataOut   (dataOut),
    .ramAddr   (ramAddr),
    .ramWr     (ramWr),
    .ramDout   (ramDout),
    .ramDin    (ramDin)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- memories ----------------
  logic [7:0] ram     [logic [31:0]];   // the RAM the DUT talks to
  logic [7:0] ref_mem [logic [31:0]];   // reference contents

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  // Little-endian, zero-extended word of n bytes from the reference memory.
  function automatic logic [31:0] rd_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < n; i++) w = w | (32'(ref_rd(a + 32'(i))) << (8 * i));
    return w;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      ram[a + 32'(i)]     = 8'(w >> (8 * i));
      ref_mem[a + 32'(i)] = 8'(w >> (8 * i));
    end
  endtask

  // Synchronous RAM: address sampled at an edge, data out after that edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rdy) begin
        ramDin <= ram_rd(ramAddr);
        if (ramWr) ram[ramAddr] = ramDout;
      end
    end
  end

  // ---------------- reference schedule ----------------
  bit          busy;
  int          off;
  bit          m_data;
  bit          m_wr;
  int          m_n;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  bit          last_data;
  bit          pick_data;
  bit          inst_req;
  logic        exp_inst_en;
  logic        exp_data_en;
  logic        exp_wr;
  logic [31:0] exp_addr;
  logic [7:0]  exp_dout;
  logic [31:0] exp_inst;
  logic [31:0] exp_data;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        busy = 0; off = 0; last_data = 0;
        exp_inst_en = 1'b0; exp_data_en = 1'b0; exp_wr = 1'b0;
        exp_addr = 32'h0; exp_dout = 8'h0; exp_inst = 32'h0; exp_data = 32'h0;
      end else if (rdy) begin
        exp_inst_en = 1'b0;
        exp_data_en = 1'b0;
        exp_wr      = 1'b0;
        if (busy) begin
          off++;
          // The RAM stores the byte that was presented in the cycle just ended.
          if (m_wr && off <= m_n)
            ref_mem[m_addr + 32'(off - 1)] = 8'(m_wd >> (8 * (off - 1)));
          if (!m_data && mistaken) begin
            busy = 0;
          end else begin
            if (off < m_n) begin
              exp_addr = m_addr + 32'(off);
              exp_wr   = m_wr;
              if (m_wr) exp_dout = 8'(m_wd >> (8 * off));
            end
            if (off == (m_wr ? m_n : m_n + 1)) begin
              busy = 0;
              if (m_data) begin
                exp_data_en = 1'b1;
                if (!m_wr) exp_data = rd_word(m_addr, m_n);
              end else begin
                exp_inst_en = 1'b1;
                exp_inst    = rd_word(m_addr, m_n);
              end
            end
          end
        end else begin
          inst_req = instEn && !mistaken;
`ifdef MEM_ARB_FAIR_EN
          pick_data = dataEn && (!inst_req || !last_data);
`else
          pick_data = dataEn;
`endif
          if (pick_data || inst_req) begin
            busy      = 1;
            off       = 0;
            m_data    = pick_data;
            m_wr      = pick_data && dataWr;
            m_n       = !pick_data ? 4 : (dataLen == 2'b00) ? 1 : (dataLen == 2'b01) ? 2 : 4;
            m_addr    = pick_data ? dataAddr : instAddr;
            m_wd      = dataIn;
            last_data = pick_data;
            exp_addr  = m_addr;
            exp_wr    = m_wr;
            if (m_wr) exp_dout = m_wd[7:0];
          end
        end
      end
    end
  end

  // Cycle compare against the reference, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk1("cyc instOutEn", instOutEn, exp_inst_en);
      chk1("cyc dataOutEn", dataOutEn, exp_data_en);
      chk1("cyc ramWr", ramWr, exp_wr);
      chk32("cyc ramAddr", ramAddr, exp_addr);
      if (exp_wr)      chk32("cyc ramDout", 32'(ramDout), 32'(exp_dout));
      if (exp_inst_en) chk32("cyc inst", inst, exp_inst);
      if (exp_data_en) chk32("cyc dataOut", dataOut, exp_data);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] seen_addr [8];

  task automatic run_txn(input bit is_data, input bit wr, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int stall_at, input int stall_len,
                         output logic [31:0] word, output int pulse_k, output int wr_cycles);
    bit seen;
    seen = 0; word = 32'h0; pulse_k = -1; wr_cycles = 0;
    if (is_data) begin
      dataEn = 1'b1; dataWr = wr; dataLen = len; dataAddr = addr; dataIn = wd;
    end else begin
      instEn = 1'b1; instAddr = addr;
    end
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (k < 8) seen_addr[k] = ramAddr;
      if (ramWr) wr_cycles++;
      if (is_data ? dataOutEn : instOutEn) begin
        seen    = 1;
        pulse_k = k;
        word    = is_data ? dataOut : inst;
        dataEn  = 1'b0;
        instEn  = 1'b0;
      end
      if (k == stall_at) rdy = 1'b0;
      if (k == stall_at + stall_len) rdy = 1'b1;
    end
    chk1("txn completes in budget", seen, 1'b1);
    $display("txn %s wr=%0d len=%0d addr=%h -> word=%h pulse after edge %0d",
             is_data ? "data" : "inst", wr, len, addr, word, pulse_k);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] w2;
    logic [31:0] a4;
    int          pk;
    int          pk2;
    int          wc;
    bit          early;

    preload(32'h100, 32'h00500013, 4);
    preload(32'h2000, 32'h77000066, 4);
    preload(32'h30, 32'h00000080, 1);
    preload(32'h200, 32'hDEADBEEF, 4);
    preload(32'h400, 32'h04030201, 4);
    preload(32'h500, 32'h44332211, 4);
    preload(32'hFFFFFFFE, 32'h0000B2A1, 2);
    preload(32'h0, 32'h0000D4C3, 2);

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset instOutEn", instOutEn, 1'b0);
    chk1("reset dataOutEn", dataOutEn, 1'b0);
    chk1("reset ramWr", ramWr, 1'b0);
    chk32("reset ramAddr", ramAddr, 32'h0);
    chk32("reset ramDout", 32'(ramDout), 32'h0);
    chk32("reset inst", inst, 32'h0);
    chk32("reset dataOut", dataOut, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 4-byte fetch
    run_txn(1'b0, 1'b0, 2'b11, 32'h100, 32'h0, -1, 0, w, pk, wc);
    chk32("fetch word", w, 32'h00500013);
    chk32("fetch latency", 32'(pk), 32'd5);
    chk32("fetch write cycles", 32'(wc), 32'd0);
    chk32("fetch addr after edge 3", seen_addr[3], 32'h103);
    @(posedge clk); #1;
    chk1("fetch pulse one cycle", instOutEn, 1'b0);

    // 2-byte unaligned store
    run_txn(1'b1, 1'b1, 2'b01, 32'h2001, 32'hAABBCCDD, -1, 0, w, pk, wc);
    chk32("store done edge", 32'(pk), 32'd2);
    chk32("store write cycles", 32'(wc), 32'd2);
    chk32("store ram 2001", 32'(ram_rd(32'h2001)), 32'hDD);
    chk32("store ram 2002", 32'(ram_rd(32'h2002)), 32'hCC);
    chk32("store ram 2003 untouched", 32'(ram_rd(32'h2003)), 32'h77);
    chk32("store ram 2000 untouched", 32'(ram_rd(32'h2000)), 32'h66);
    @(posedge clk); #1;

    // Simultaneous requests: 1-byte load vs fetch
    dataEn = 1'b1; dataWr = 1'b0; dataLen = 2'b00; dataAddr = 32'h30;
    instEn = 1'b1; instAddr = 32'h100;
    pk = -1; pk2 = -1; w = 32'h0; w2 = 32'h0;
    for (int k = 0; k < 40 && (pk < 0 || pk2 < 0); k++) begin
      @(posedge clk); #1;
      if (dataOutEn) begin pk = k; w = dataOut; dataEn = 1'b0; end
      if (instOutEn) begin pk2 = k; w2 = inst; instEn = 1'b0; end
    end
    $display("txn both-pending -> data %h after edge %0d, inst %h after edge %0d", w, pk, w2, pk2);
    chk32("arb load data", w, 32'h00000080);
    chk32("arb fetch data", w2, 32'h00500013);
`ifdef MEM_ARB_FAIR_EN
    chk32("arb fetch edge", 32'(pk2), 32'd5);
    chk32("arb load edge", 32'(pk), 32'd8);
`else
    chk32("arb load edge", 32'(pk), 32'd2);
    chk32("arb fetch edge", 32'(pk2), 32'd8);
`endif
    @(posedge clk); #1;

    // Flushed fetch at 0x200, then a fresh fetch at 0x400
    instEn = 1'b1; instAddr = 32'h200; early = 0;
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk); #1;
      if (instOutEn) early = 1;
      if (k == 2) mistaken = 1'b1;
      if (k == 3) begin mistaken = 1'b0; instAddr = 32'h400; end
    end
    pk = -1; w = 32'h0; a4 = 32'h0;
    for (int k = 4; k < 40 && pk < 0; k++) begin
      @(posedge clk); #1;
      if (k == 4) a4 = ramAddr;
      if (instOutEn) begin pk = k; w = inst; instEn = 1'b0; end
    end
    $display("txn flushed fetch 200, refetch 400 -> %h after edge %0d", w, pk);
    chk1("flush no pulse", early, 1'b0);
    chk32("refetch granted edge 4", a4, 32'h400);
    chk32("refetch edge", 32'(pk), 32'd9);
    chk32("refetch word", w, 32'h04030201);
    @(posedge clk); #1;

    // 4-byte load with a 3-cycle rdy stall
    run_txn(1'b1, 1'b0, 2'b11, 32'h500, 32'h0, 2, 3, w, pk, wc);
    chk32("stall load word", w, 32'h44332211);
    chk32("stall load edge", 32'(pk), 32'd8);
    @(posedge clk); #1;

    // dataLen 10 behaves as a word; 2-byte load zero-extends
    run_txn(1'b1, 1'b0, 2'b10, 32'h500, 32'h0, -1, 0, w, pk, wc);
    chk32("len10 word", w, 32'h44332211);
    chk32("len10 edge", 32'(pk), 32'd5);
    run_txn(1'b1, 1'b0, 2'b01, 32'h501, 32'h0, -1, 0, w, pk, wc);
    chk32("half word", w, 32'h00003322);
    chk32("half edge", 32'(pk), 32'd3);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a store
    dataEn = 1'b1; dataWr = 1'b1; dataLen = 2'b11; dataAddr = 32'h600; dataIn = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk1("store active before reset", ramWr, 1'b1);
    rst = 1'b0; dataEn = 1'b0; dataWr = 1'b0;
    #1;
    $display("txn store 600 interrupted by reset");
    chk1("async reset ramWr", ramWr, 1'b0);
    chk32("async reset ramAddr", ramAddr, 32'h0);
    chk32("async reset ramDout", 32'(ramDout), 32'h0);
    chk32("async reset inst", inst, 32'h0);
    chk32("async reset dataOut", dataOut, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Wrapping 4-byte load
    run_txn(1'b1, 1'b0, 2'b11, 32'hFFFFFFFE, 32'h0, -1, 0, w, pk, wc);
    chk32("wrap addr 0", seen_addr[0], 32'hFFFFFFFE);
    chk32("wrap addr 1", seen_addr[1], 32'hFFFFFFFF);
    chk32("wrap addr 2", seen_addr[2], 32'h00000000);
    chk32("wrap addr 3", seen_addr[3], 32'h00000001);
    chk32("wrap word", w, 32'hD4C3B2A1);
    chk32("wrap edge", 32'(pk), 32'd5);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
